microwave_ctrl: RTL and testbench
=================================

Name: microwave_ctrl

Overview:
- Parametrised successor to the single-latch magnetron enable.
- Adds a cook-time countdown, a power-level duty cycle and pause/resume.
- Replaces the set/reset latch with a clocked four-state FSM, so door, stop, clear and timer events are resolved cycle-accurately.
- Sits between front-panel decode (active-low buttons, door switch) and the magnetron driver.

Parameters:
- TIME_W, 12, width of cook-time counter in seconds (max 2^TIME_W-1 s).
- TICK_DIV, 1000, clock cycles per one-second tick (>=2).
- PWR_LEVELS, 10, duty-cycle window length in seconds; power p gives p seconds on per window.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- door_closed  input  1  1 = door shut; synchronous to clk.
- startn  input  1  start button, active low, level-sampled each cycle.
- stopn  input  1  stop/pause button, active low.
- clearn  input  1  clear/cancel button, active low.
- load_time  input  1  load time_in/power_in; honoured in IDLE only.
- time_in  input  TIME_W  requested cook time, seconds.
- power_in  input  $clog2(PWR_LEVELS+1)  requested power level 0..PWR_LEVELS.
- magnetron_on  output  1  magnetron drive.
- time_left  output  TIME_W  remaining seconds.
- state  output  2  IDLE=0, COOK=1, PAUSE=2, DONE=3.
- done  output  1  high while in DONE.

Behaviour:
Reset (resetn low, asynchronous):
- state=IDLE.
- time_left=0, power=0, tick counter=0, pwr_phase=0.
- magnetron_on=0, done=0.

Event priority per cycle: clear (clearn=0) > stop (stopn=0 or door_closed=0) > start (startn=0).

IDLE:
- load_time=1: time_left<=time_in; power<=min(power_in, PWR_LEVELS).
- start && door_closed && time_left!=0 -> COOK. Tick counter and pwr_phase cleared on entry.
- clear: time_left<=0, power<=0.
- Start with time_left=0 is ignored.

COOK:
- Tick counter counts 0..TICK_DIV-1 and wraps; tick asserts on the TICK_DIV-1 cycle.
- On tick:
  - time_left decrements.
  - pwr_phase increments modulo PWR_LEVELS.
  - If time_left was 1: go to DONE next cycle; time_left=0.
- Stop -> PAUSE. Tick counter and pwr_phase hold.
- Stop coinciding with a tick: the decrement is applied, then PAUSE. If that decrement reaches 0, DONE wins.
- Clear -> IDLE; time_left<=0.
- load_time is ignored.

PAUSE:
- All counters hold.
- start && door_closed -> COOK. Counting resumes from the held tick count (no restart of the partial second).
- Clear -> IDLE; time_left<=0.

DONE:
- done=1.
- Clear, or door_closed falling -> IDLE; time_left stays 0.
- Start is ignored.

magnetron_on:
- magnetron_on = (state==COOK) && door_closed && (pwr_phase < power).
- It is combinationally gated by door_closed, so door opening drops drive in the same cycle as the event.
- power=0: never on. power=PWR_LEVELS: always on in COOK.

Arithmetic:
- time_left never underflows.
- pwr_phase width is $clog2(PWR_LEVELS).

Reset mid-cook: immediate return to reset values; magnetron_on drops asynchronously.

Optional Feature:
- Macro: MWAVE_QUICKSTART_EN.
- Defined:
  - Start in IDLE with time_left=0 and door closed loads 30 s at full power and enters COOK.
  - Start in COOK adds 30 s to time_left, saturating at 2^TIME_W-1. The add is applied once per startn falling edge, not per cycle held.
- Undefined: both cases are ignored, as described above.

Decomposition:
- Package mwave_pkg:
  - state enum and its 2-bit encoding.
  - QUICK_ADD_S=30.
  - Helper function for power clamp.
- Sub-module mwave_tick_gen:
  - TICK_DIV prescaler with enable (COOK) and synchronous clear (entry to COOK from IDLE).
  - Outputs a one-cycle tick.

Test Plan (TICK_DIV=4, PWR_LEVELS=4, TIME_W=8):
1. load time_in=3, power_in=4, start with door closed -> COOK; magnetron_on=1 for 12 cycles; time_left 3->2->1->0; DONE with done=1; magnetron_on=0.
2. power_in=2, time_in=8 -> magnetron_on high 2 ticks, low 2 ticks, repeating; total 16 on-cycles over 32.
3. Open door mid-second in COOK at time_left=5 -> magnetron_on falls same cycle; PAUSE; close door and start -> COOK; remaining partial second completes before time_left=4.
4. stopn low on the tick cycle at time_left=1 -> DONE (not PAUSE); time_left=0.
5. clearn and startn low together in PAUSE -> IDLE, time_left=0; start from IDLE with time_left=0 -> stays IDLE (macro undefined).
6. resetn low during COOK with time_left=7 -> all outputs 0 and state=IDLE immediately; with MWAVE_QUICKSTART_EN, start after reset -> COOK with time_left=30, power 4.

Source files
------------

// File: rtl/mwave_pkg.sv
// =============================================================================
// mwave_pkg: shared state encoding, quick-start constant and power clamp helper
// Rev 1.0
// =============================================================================
`default_nettype none

package mwave_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COOK  = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } mwave_state_e;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_COOK  = 2'd1;
   localparam logic [1:0] S_PAUSE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam int QUICK_ADD_S = 30;

   function automatic int unsigned pwr_clamp(input int unsigned p, input int unsigned max_p);
      return (p > max_p) ? max_p : p;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mwave_tick_gen.sv
// =============================================================================
// mwave_tick_gen: one-second prescaler, one-cycle tick on the last count
// Rev 1.0
// =============================================================================
`default_nettype none

module mwave_tick_gen #(
   parameter int TICK_DIV = 1000
) (
   input  logic clk,
   input  logic resetn,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick = en && (cnt_q == CNT_MAX);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/microwave_ctrl.sv
// =============================================================================
// microwave_ctrl: cook-time countdown, power duty cycle, pause/resume FSM.
// Optional build macro: MWAVE_QUICKSTART_EN (30 s quick start / +30 s add). Rev 1.0
// =============================================================================
`default_nettype none

module microwave_ctrl
   import mwave_pkg::*;
#(
   parameter int TIME_W     = 12,
   parameter int TICK_DIV   = 1000,
   parameter int PWR_LEVELS = 10
) (
   input  logic                              clk,
   input  logic                              resetn,
   input  logic                              door_closed,
   input  logic                              startn,
   input  logic                              stopn,
   input  logic                              clearn,
   input  logic                              load_time,
   input  logic [TIME_W-1:0]                 time_in,
   input  logic [$clog2(PWR_LEVELS+1)-1:0]   power_in,
   output logic                              magnetron_on,
   output logic [TIME_W-1:0]                 time_left,
   output logic [1:0]                        state,
   output logic                              done
);

   localparam int PW_W = $clog2(PWR_LEVELS + 1);
   localparam int PH_W = (PWR_LEVELS > 1) ? $clog2(PWR_LEVELS) : 1;

   logic [1:0]        state_q,     state_d;
   logic [TIME_W-1:0] time_left_q, time_left_d;
   logic [PW_W-1:0]   power_q,     power_d;
   logic [PH_W-1:0]   pwr_phase_q, pwr_phase_d;
   logic              door_prev_q, door_prev_d;

   logic            tick;
   logic            tick_clr;
   logic            ev_clear;
   logic            ev_stop;
   logic            ev_start;
   logic            door_fall;
   logic [PW_W-1:0] power_in_clamped;

   assign ev_clear  = ~clearn;
   assign ev_stop   = ~stopn | ~door_closed;
   assign ev_start  = ~startn;
   assign door_fall = door_prev_q & ~door_closed;

   assign power_in_clamped = PW_W'(pwr_clamp(32'(power_in), PWR_LEVELS));

`ifdef MWAVE_QUICKSTART_EN
   localparam logic [TIME_W-1:0] QUICK_T = (TIME_W >= 5) ? TIME_W'(QUICK_ADD_S) : '1;

   logic start_prev_q, start_prev_d;
   logic start_edge;

   // The +30 s add fires once per press, not once per held cycle.
   assign start_prev_d = ev_start;
   assign start_edge   = ev_start & ~start_prev_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         start_prev_q <= 1'b0;
      end else begin
         start_prev_q <= start_prev_d;
      end
   end

   function automatic logic [TIME_W-1:0] sat_add_quick(input logic [TIME_W-1:0] t);
      logic [TIME_W:0] sum;
      sum = {1'b0, t} + {1'b0, QUICK_T};
      return sum[TIME_W] ? '1 : sum[TIME_W-1:0];
   endfunction
`endif

   mwave_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk    (clk),
      .resetn (resetn),
      .en     (state_q == S_COOK),
      .clr    (tick_clr),
      .tick   (tick)
   );

   always_comb begin
      state_d     = state_q;
      time_left_d = time_left_q;
      power_d     = power_q;
      pwr_phase_d = pwr_phase_q;
      door_prev_d = door_closed;
      tick_clr    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (ev_clear) begin
               time_left_d = '0;
               power_d     = '0;
            end else begin
               if (load_time) begin
                  time_left_d = time_in;
                  power_d     = power_in_clamped;
               end
               // A stop event includes an open door, so !ev_stop implies door closed.
               if (ev_start && !ev_stop) begin
                  if (time_left_d != '0) begin
                     state_d     = S_COOK;
                     tick_clr    = 1'b1;
                     pwr_phase_d = '0;
                  end
`ifdef MWAVE_QUICKSTART_EN
                  else begin
                     time_left_d = QUICK_T;
                     power_d     = PW_W'(PWR_LEVELS);
                     state_d     = S_COOK;
                     tick_clr    = 1'b1;
                     pwr_phase_d = '0;
                  end
`endif
               end
            end
         end

         S_COOK: begin
            if (ev_clear) begin
               state_d     = S_IDLE;
               time_left_d = '0;
            end else begin
               if (tick) begin
                  if (time_left_q != '0) begin
                     time_left_d = time_left_q - TIME_W'(1);
                  end
                  pwr_phase_d = (pwr_phase_q == PH_W'(PWR_LEVELS - 1)) ? '0
                                                                      : pwr_phase_q + PH_W'(1);
               end
`ifdef MWAVE_QUICKSTART_EN
               if (start_edge && !ev_stop) begin
                  time_left_d = sat_add_quick(time_left_d);
               end
`endif
               // Expiry beats a coincident stop.
               if (tick && (time_left_d == '0)) begin
                  state_d = S_DONE;
               end else if (ev_stop) begin
                  state_d = S_PAUSE;
               end
            end
         end

         S_PAUSE: begin
            if (ev_clear) begin
               state_d     = S_IDLE;
               time_left_d = '0;
            end else if (ev_start && !ev_stop) begin
               state_d = S_COOK;
            end
         end

         S_DONE: begin
            if (ev_clear || door_fall) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         time_left_q <= '0;
         power_q     <= '0;
         pwr_phase_q <= '0;
         door_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         time_left_q <= time_left_d;
         power_q     <= power_d;
         pwr_phase_q <= pwr_phase_d;
         door_prev_q <= door_prev_d;
      end
   end

   assign magnetron_on = (state_q == S_COOK) && door_closed &&
                         (32'(pwr_phase_q) < 32'(power_q));
   assign time_left    = time_left_q;
   assign state        = state_q;
   assign done         = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_microwave_ctrl.sv
// =============================================================================
// tb_microwave_ctrl: vector table plus hand sequences, scoreboard-checked
// Rev 1.0
// =============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_microwave_ctrl;

   localparam int TIME_W     = 8;
   localparam int TICK_DIV   = 4;
   localparam int PWR_LEVELS = 4;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] COOK  = 2'd1;
   localparam logic [1:0] PAUSE = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       door_closed = 1'b1;
   logic       startn = 1'b1;
   logic       stopn = 1'b1;
   logic       clearn = 1'b1;
   logic       load_time = 1'b0;
   logic [7:0] time_in = '0;
   logic [2:0] power_in = '0;
   logic       magnetron_on;
   logic [7:0] time_left;
   logic [1:0] state;
   logic       done;

   microwave_ctrl #(
      .TIME_W     (TIME_W),
      .TICK_DIV   (TICK_DIV),
      .PWR_LEVELS (PWR_LEVELS)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .door_closed  (door_closed),
      .startn       (startn),
      .stopn        (stopn),
      .clearn       (clearn),
      .load_time    (load_time),
      .time_in      (time_in),
      .power_in     (power_in),
      .magnetron_on (magnetron_on),
      .time_left    (time_left),
      .state        (state),
      .done         (done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       door;
      logic       startn;
      logic       stopn;
      logic       clearn;
      logic       load;
      logic [7:0] tin;
      logic [2:0] pin;
   } stim_t;

   typedef struct packed {
      logic       mag;
      logic [7:0] tl;
      logic [1:0] st;
      logic       dn;
   } exp_t;

   typedef struct {
      stim_t s;
      exp_t  e;
      int    test;
   } vec_t;

   exp_t exp_q[$];
   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic stim_t st(logic door, logic sn, logic pn, logic cn, logic ld,
                                int tin, int pin);
      stim_t s;
      s.door = door; s.startn = sn; s.stopn = pn; s.clearn = cn; s.load = ld;
      s.tin = 8'(tin); s.pin = 3'(pin);
      return s;
   endfunction

   function automatic exp_t ex(logic m, int tl, logic [1:0] s, logic d);
      exp_t e;
      e.mag = m; e.tl = 8'(tl); e.st = s; e.dn = d;
      return e;
   endfunction

   function automatic stim_t idle_s();
      return st(1, 1, 1, 1, 0, 0, 0);
   endfunction

   function automatic stim_t start_s();
      return st(1, 0, 1, 1, 0, 0, 0);
   endfunction

   function automatic stim_t clear_s();
      return st(1, 1, 1, 0, 0, 0, 0);
   endfunction

   function automatic stim_t load_s(int t, int p);
      return st(1, 1, 1, 1, 1, t, p);
   endfunction

   task automatic drive(input stim_t s);
      door_closed = s.door;
      startn      = s.startn;
      stopn       = s.stopn;
      clearn      = s.clearn;
      load_time   = s.load;
      time_in     = s.tin;
      power_in    = s.pin;
   endtask

   task automatic check_out(input string tag);
      exp_t e;
      exp_t a;
      e = exp_q.pop_front();
      a = {magnetron_on, time_left, state, done};
      n_checks++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got mag=%0b tl=%0d st=%0d done=%0b, want mag=%0b tl=%0d st=%0d done=%0b",
                  tag, a.mag, a.tl, a.st, a.dn, e.mag, e.tl, e.st, e.dn);
      end
   endtask

   task automatic check_now(input exp_t e, input string tag);
      exp_q.push_back(e);
      check_out(tag);
   endtask

   // Inputs change on the falling edge; results are sampled 1 ns after the rising edge.
   task automatic cycle(input stim_t s, input exp_t e, input string tag);
      @(negedge clk);
      drive(s);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      check_out(tag);
   endtask

   task automatic add(input int test, input stim_t s, input exp_t e);
      vec_t v;
      v.s = s; v.e = e; v.test = test;
      vecs.push_back(v);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, want end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int on_cnt;

      // Test 1: full power, 3 s, end via door opening in DONE.
      add(1, load_s(3, 4), ex(0, 3, IDLE, 0));
      add(1, start_s(),    ex(1, 3, COOK, 0));
      for (int k = 1; k < 12; k++) add(1, idle_s(), ex(1, 3 - k / 4, COOK, 0));
      add(1, idle_s(),                    ex(0, 0, DONE, 1));
      add(1, st(0, 1, 1, 1, 0, 0, 0),     ex(0, 0, IDLE, 0));
      add(1, idle_s(),                    ex(0, 0, IDLE, 0));
      // Test 2: half power, 8 s, start ignored in DONE, then clear.
      add(2, load_s(8, 2), ex(0, 8, IDLE, 0));
      add(2, start_s(),    ex(1, 8, COOK, 0));
      for (int k = 1; k < 32; k++)
         add(2, idle_s(), ex(((k / 4) % 4) < 2, 8 - k / 4, COOK, 0));
      add(2, idle_s(),  ex(0, 0, DONE, 1));
      add(2, start_s(), ex(0, 0, DONE, 1));
      add(2, clear_s(), ex(0, 0, IDLE, 0));

      repeat (3) @(negedge clk);
      check_now(ex(0, 0, IDLE, 0), "reset_state");
      resetn = 1'b1;
      @(posedge clk);
      #1;
      check_now(ex(0, 0, IDLE, 0), "after_reset_release");

      on_cnt = 0;
      for (int i = 0; i < vecs.size(); i++) begin
         cycle(vecs[i].s, vecs[i].e, $sformatf("vec%0d_test%0d", i, vecs[i].test));
         if (vecs[i].test == 2 && magnetron_on) on_cnt++;
      end
      n_checks++;
      if (on_cnt != 16) begin
         n_fail++;
         $display("FAIL duty_on_cycles: got %0d, want 16", on_cnt);
      end

      // Test 3: door opened mid-second at 5 s, resume keeps partial second.
      cycle(load_s(6, 4), ex(0, 6, IDLE, 0), "t3_load");
      cycle(start_s(),    ex(1, 6, COOK, 0), "t3_start");
      for (int k = 1; k <= 5; k++)
         cycle(idle_s(), ex(1, (k < 4) ? 6 : 5, COOK, 0), $sformatf("t3_cook%0d", k));
      @(negedge clk);
      drive(st(0, 1, 1, 1, 0, 0, 0));
      #1;
      check_now(ex(0, 5, COOK, 0), "t3_door_comb_drop");
      exp_q.push_back(ex(0, 5, PAUSE, 0));
      @(posedge clk);
      #1;
      check_out("t3_pause");
      cycle(st(0, 1, 1, 1, 0, 0, 0), ex(0, 5, PAUSE, 0), "t3_pause_hold");
      cycle(idle_s(),  ex(0, 5, PAUSE, 0), "t3_door_closed_no_start");
      cycle(start_s(), ex(1, 5, COOK, 0),  "t3_resume");
      cycle(idle_s(),  ex(1, 5, COOK, 0),  "t3_partial");
      cycle(idle_s(),  ex(1, 4, COOK, 0),  "t3_partial_done");
      cycle(clear_s(), ex(0, 0, IDLE, 0),  "t3_clear");

      // Test 4: stop on a tick -> decrement then PAUSE; stop on final tick -> DONE.
      cycle(load_s(3, 7), ex(0, 3, IDLE, 0), "t4_load_clamp");
      cycle(start_s(),    ex(1, 3, COOK, 0), "t4_start");
      for (int k = 1; k <= 3; k++) cycle(idle_s(), ex(1, 3, COOK, 0), $sformatf("t4_cook%0d", k));
      cycle(st(1, 1, 0, 1, 0, 0, 0), ex(0, 2, PAUSE, 0), "t4_stop_on_tick");
      cycle(start_s(), ex(1, 2, COOK, 0), "t4_resume");
      for (int k = 1; k <= 3; k++) cycle(idle_s(), ex(1, 2, COOK, 0), $sformatf("t4_r%0d", k));
      for (int k = 4; k <= 7; k++) cycle(idle_s(), ex(1, 1, COOK, 0), $sformatf("t4_r%0d", k));
      cycle(st(1, 1, 0, 1, 0, 0, 0), ex(0, 0, DONE, 1), "t4_stop_final_tick_done");
      cycle(clear_s(), ex(0, 0, IDLE, 0), "t4_clear");

      // Test 5: zero power never drives; clear beats start in PAUSE.
      cycle(load_s(5, 0), ex(0, 5, IDLE, 0),  "t5_load");
      cycle(start_s(),    ex(0, 5, COOK, 0),  "t5_start_pwr0");
      cycle(idle_s(),     ex(0, 5, COOK, 0),  "t5_cook_pwr0");
      cycle(st(1, 1, 0, 1, 0, 0, 0), ex(0, 5, PAUSE, 0), "t5_stop");
      cycle(st(1, 0, 1, 0, 0, 0, 0), ex(0, 0, IDLE, 0),  "t5_clear_and_start");
`ifdef MWAVE_QUICKSTART_EN
      cycle(start_s(), ex(1, 30, COOK, 0), "t5_quickstart");
      cycle(idle_s(),  ex(1, 30, COOK, 0), "t5_qs_release");
      cycle(start_s(), ex(1, 60, COOK, 0), "t5_qs_add");
      cycle(start_s(), ex(1, 60, COOK, 0), "t5_qs_add_held");
      cycle(idle_s(),  ex(1, 59, COOK, 0), "t5_qs_tick");
      cycle(clear_s(), ex(0, 0, IDLE, 0),  "t5_qs_clear");
`else
      cycle(start_s(), ex(0, 0, IDLE, 0), "t5_start_zero_time");
      cycle(idle_s(),  ex(0, 0, IDLE, 0), "t5_idle_hold");
`endif

      // Test 6: asynchronous reset mid-cook.
      cycle(load_s(7, 4), ex(0, 7, IDLE, 0), "t6_load");
      cycle(start_s(),    ex(1, 7, COOK, 0), "t6_start");
      cycle(idle_s(),     ex(1, 7, COOK, 0), "t6_cook");
      @(negedge clk);
      #2;
      resetn = 1'b0;
      #1;
      check_now(ex(0, 0, IDLE, 0), "t6_async_reset");
      @(negedge clk);
      resetn = 1'b1;
      check_now(ex(0, 0, IDLE, 0), "t6_reset_released");
`ifdef MWAVE_QUICKSTART_EN
      cycle(start_s(), ex(1, 30, COOK, 0), "t6_quickstart_after_reset");
      cycle(idle_s(),  ex(1, 30, COOK, 0), "t6_qs_full_power");
`else
      cycle(start_s(), ex(0, 0, IDLE, 0), "t6_start_after_reset");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
